// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_pkg;

  localparam int unsigned MEM_BYTES_DEFAULT = 80;
  localparam int unsigned WORD_W            = 32;
  localparam int unsigned BYTES_PER_WORD    = 4;
  localparam int unsigned LANE_W            = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    StIdle,
    StRecv,
    StWrite,
    StCheck,
    StDone,
    StErr
  } state_e;

endpackage

// File: rtl/imem_word_packer.sv
// Packs a byte stream into little-endian words; flags the byte that completes a word.
module imem_word_packer
  import imem_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              byte_en_i,
  input  logic [7:0]        byte_i,
  output logic [WORD_W-1:0] word_o,
  output logic              word_full_o
);

  logic [LANE_W-1:0] lane_q, lane_d;
  logic [WORD_W-1:0] word_q, word_d;

  always_comb begin
    lane_d = lane_q;
    word_d = word_q;
    if (clear_i) begin
      lane_d = '0;
      word_d = '0;
    end else if (byte_en_i) begin
      word_d[{lane_q, 3'b000} +: 8] = byte_i;
      lane_d = lane_q + 1'b1;
    end
  end

  // word_o already includes the byte accepted this cycle
  assign word_o      = word_d;
  assign word_full_o = byte_en_i && !clear_i && (lane_q == LANE_W'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      lane_q <= '0;
      word_q <= '0;
    end else begin
      lane_q <= lane_d;
      word_q <= word_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Streams a byte image into instruction memory, verifies its checksum and releases the core.
module imem_loader
  import imem_pkg::*;
#(
  parameter int unsigned MEM_BYTES     = MEM_BYTES_DEFAULT,
  parameter int unsigned ADDR_W        = 64,
  parameter bit          HOLD_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic [15:0]       load_len,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              core_hold,
  output logic              done,
  output logic              error
);

  state_e            state_q, state_d;
  logic [15:0]       count_q, count_d;
  logic [15:0]       len_q, len_d;
  logic [7:0]        sum_q, sum_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              hold_q, hold_d;

  logic              start_ok;
  logic              len_bad;
  logic              accept;
  logic              pack_en;
  logic [7:0]        sum_next;
  logic [WORD_W-1:0] packed_word;
  logic              word_full;

  imem_word_packer u_packer (
    .clk         (clk),
    .reset       (reset),
    .clear_i     (start_ok),
    .byte_en_i   (pack_en),
    .byte_i      (byte_data),
    .word_o      (packed_word),
    .word_full_o (word_full)
  );

  always_comb begin
    byte_ready = (state_q == StRecv) || (state_q == StCheck);
    accept     = byte_valid && byte_ready;
    pack_en    = accept && (state_q == StRecv);
    start_ok   = load_start &&
                 ((state_q == StIdle) || (state_q == StDone) || (state_q == StErr));
    len_bad    = (load_len[1:0] != 2'b00) || (32'(load_len) > MEM_BYTES);
    sum_next   = sum_q + byte_data;
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    len_d   = len_q;
    sum_d   = sum_q;
    addr_d  = addr_q;
    data_d  = data_q;
    done_d  = done_q;
    error_d = error_q;
    hold_d  = hold_q;

    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (start_ok) begin
          done_d  = 1'b0;
          error_d = 1'b0;
          hold_d  = 1'b1;
          count_d = '0;
          sum_d   = '0;
          addr_d  = '0;
          len_d   = load_len;
          if (len_bad) begin
            state_d = StErr;
            error_d = 1'b1;
          end else if (load_len == 16'd0) begin
            state_d = StCheck;
          end else begin
            state_d = StRecv;
          end
        end
      end
      StRecv: begin
        if (accept) begin
          sum_d   = sum_next;
          count_d = count_q + 16'd1;
          if (word_full) begin
            data_d  = packed_word;
            state_d = StWrite;
          end
        end
      end
      StWrite: begin
        addr_d  = addr_q + ADDR_W'(BYTES_PER_WORD);
        state_d = (count_q == len_q) ? StCheck : StRecv;
      end
      StCheck: begin
        if (accept) begin
          if (sum_next == 8'd0) begin
            state_d = StDone;
            done_d  = 1'b1;
            hold_d  = 1'b0;
          end else begin
            state_d = StErr;
            error_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      count_q <= '0;
      len_q   <= '0;
      sum_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      hold_q  <= HOLD_ON_RESET;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      len_q   <= len_d;
      sum_q   <= sum_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      done_q  <= done_d;
      error_q <= error_d;
      hold_q  <= hold_d;
    end
  end

  assign wr_en     = (state_q == StWrite);
  assign wr_addr   = addr_q;
  assign wr_data   = data_q;
  assign core_hold = hold_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomised scoreboard bench for imem_loader: expected writes queued per load, checked by a monitor.
module tb_imem_loader;

  localparam int unsigned ADDR_W    = 64;
  localparam int unsigned MEM_BYTES = 80;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              load_start = 1'b0;
  logic [15:0]       load_len = '0;
  logic              byte_valid = 1'b0;
  logic [7:0]        byte_data = '0;
  logic              byte_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              core_hold;
  logic              done;
  logic              error;

  imem_loader #(
    .MEM_BYTES     (MEM_BYTES),
    .ADDR_W        (ADDR_W),
    .HOLD_ON_RESET (1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .load_start (load_start),
    .load_len   (load_len),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .core_hold  (core_hold),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         expq[$];
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  payload[0:127];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write must match the next expected word and never overlap byte_ready.
  always @(negedge clk) begin
    if (reset && wr_en) begin
      if (expq.size() == 0) begin
        check("unexpected_write", wr_addr, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        wr_t e;
        e = expq.pop_front();
        check("wr_addr", wr_addr, e.addr);
        check("wr_data", 64'(wr_data), 64'(e.data));
        check("ready_in_write", 64'(byte_ready), 64'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    byte_valid = 1'b0;
    repeat (gap) tick();
    byte_valid = 1'b1;
    byte_data  = b;
    n = 0;
    forever begin
      @(negedge clk);
      if (byte_ready) begin
        tick();
        byte_valid = 1'b0;
        break;
      end
      n++;
      if (n > 200) begin
        check("handshake_timeout", 64'd1, 64'd0);
        byte_valid = 1'b0;
        break;
      end
    end
  endtask

  task automatic pulse_start(input logic [15:0] len);
    load_start = 1'b1;
    load_len   = len;
    tick();
    load_start = 1'b0;
  endtask

  // Reference: words are little-endian groups of payload; image passes when bytes+checksum sum to 0 mod 256.
  task automatic run_load(input logic [15:0] len, input bit good, input int max_gap,
                          input int ghost_at);
    int         s;
    logic [7:0] c;
    bit         bad;
    bad = (len % 4 != 0) || (int'(len) > MEM_BYTES);
    if (bad) begin
      pulse_start(len);
      repeat (3) begin
        @(negedge clk);
        check("len_err_ready", 64'(byte_ready), 64'd0);
      end
      check("len_err_error", 64'(error), 64'd1);
      check("len_err_done", 64'(done), 64'd0);
      check("len_err_hold", 64'(core_hold), 64'd1);
      tick();
      return;
    end
    s = 0;
    for (int i = 0; i < int'(len); i++) s += int'(payload[i]);
    for (int w = 0; w < int'(len) / 4; w++) begin
      wr_t e;
      e.addr = 64'(4 * w);
      e.data = {payload[4*w+3], payload[4*w+2], payload[4*w+1], payload[4*w]};
      expq.push_back(e);
    end
    if (good) c = 8'((256 - (s % 256)) % 256);
    else      c = 8'((256 - (s % 256) + 1 + int'($urandom_range(0, 254))) % 256);
    pulse_start(len);
    for (int i = 0; i < int'(len); i++) begin
      if (i == ghost_at) pulse_start(16'd4);
      send_byte(payload[i], int'($urandom_range(0, max_gap)));
    end
    send_byte(c, int'($urandom_range(0, max_gap)));
    @(negedge clk);
    check("done", 64'(done), good ? 64'd1 : 64'd0);
    check("error", 64'(error), good ? 64'd0 : 64'd1);
    check("core_hold", 64'(core_hold), good ? 64'd0 : 64'd1);
    check("writes_drained", 64'(expq.size()), 64'd0);
    tick();
  endtask

  task automatic load_demo();
    payload[0] = 8'h13; payload[1] = 8'h05; payload[2] = 8'h00; payload[3] = 8'h00;
    payload[4] = 8'h93; payload[5] = 8'h05; payload[6] = 8'h40; payload[7] = 8'h00;
  endtask

  task automatic check_reset_outputs();
    check("rst_ready", 64'(byte_ready), 64'd0);
    check("rst_wr_en", 64'(wr_en), 64'd0);
    check("rst_wr_addr", wr_addr, 64'd0);
    check("rst_wr_data", 64'(wr_data), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_hold", 64'(core_hold), 64'd1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    tick();
    reset = 1'b1;
    tick();

    // Known-good image, then same image with a wrong checksum
    load_demo();
    run_load(16'd8, 1'b1, 0, -1);
    run_load(16'd8, 1'b0, 0, -1);

    // Illegal lengths
    run_load(16'd6, 1'b1, 0, -1);
    run_load(16'd84, 1'b1, 0, -1);

    // Backpressure with random gaps, plus an ignored load_start mid-RECV
    for (int i = 0; i < 16; i++) payload[i] = 8'($urandom);
    run_load(16'd16, 1'b1, 3, -1);
    run_load(16'd16, 1'b1, 2, 2);

    // Reset after 3 of 8 bytes: no write, outputs back to reset values
    load_demo();
    pulse_start(16'd8);
    for (int i = 0; i < 3; i++) send_byte(payload[i], 0);
    reset = 1'b0;
    tick();
    @(negedge clk);
    check_reset_outputs();
    tick();
    reset = 1'b1;
    tick();
    run_load(16'd8, 1'b1, 1, -1);

    // Empty image
    run_load(16'd0, 1'b1, 0, -1);

    // Random images, including full capacity
    for (int t = 0; t < 10; t++) begin
      int len;
      len = (t == 0) ? int'(MEM_BYTES) : 4 * int'($urandom_range(1, MEM_BYTES / 4));
      for (int i = 0; i < len; i++) payload[i] = 8'($urandom);
      run_load(16'(len), ($urandom_range(0, 3) != 0), 2, (len >= 8) ? 5 : -1);
    end

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the byte-addressed, little-endian instruction memory.
- Accepts a byte stream over a valid/ready handshake and packs each 4 bytes into a 32-bit instruction word, low byte first.
- Drives a word write port into the instruction memory at ascending word addresses starting at 0.
- Holds the pipelined core stalled until the image is loaded and its checksum verifies.

Parameters:
MEM_BYTES, 80, capacity of the instruction memory in bytes; must be a multiple of 4
ADDR_W, 64, width of the instruction address bus, matching the fetch-side address width
HOLD_ON_RESET, 1, reset value of core_hold

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-low reset
load_start  input  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR
load_len  input  16  payload length in bytes, sampled on load_start
byte_valid  input  1  byte_data is valid
byte_data  input  8  stream byte
byte_ready  output  1  loader accepts byte_data this cycle
wr_en  output  1  instruction-memory write strobe, one cycle per word
wr_addr  output  ADDR_W  byte address of the word being written, always a multiple of 4
wr_data  output  32  packed word; byte 0 of the group in [7:0], byte 3 in [31:24]
core_hold  output  1  stall the core while high
done  output  1  load finished and checksum matched; level
error  output  1  load rejected or checksum mismatch; level

Behaviour:
- Reset (reset==0 at a clock edge):
  - State goes to IDLE; byte_ready=0, wr_en=0, wr_addr=0, wr_data=0, done=0, error=0, core_hold=HOLD_ON_RESET.
  - Byte counter, lane index and checksum accumulator are cleared.
  - Memory contents are not touched.
  - Reset mid-load discards any partial word and issues no write.
- A byte transfers only on a clock edge where byte_valid && byte_ready.
- States: IDLE, RECV, WRITE, CHECK, DONE, ERR.
- IDLE, DONE or ERR, on load_start:
  - If load_len[1:0]!=0 or load_len>MEM_BYTES: go to ERR; error=1, core_hold=1, no writes.
  - Else if load_len==0: go to CHECK.
  - Else: go to RECV.
  - In all cases: clear done and error, set core_hold=1, clear the counter and checksum, and set the next word address to 0.
- RECV:
  - byte_ready=1.
  - Each accepted byte goes into lane (count mod 4) and is added mod 256 to the checksum; count increments.
  - On acceptance of the 4th byte of a word, go to WRITE.
- WRITE (exactly 1 cycle):
  - wr_en=1 with wr_addr and wr_data stable; byte_ready=0.
  - Next cycle: wr_addr advances by 4 (effective for the next write), wr_en returns to 0.
  - Go to CHECK if count==load_len, else to RECV.
  - Write latency: wr_en asserts the cycle after the 4th byte is accepted.
- CHECK:
  - byte_ready=1; accept exactly one checksum byte.
  - If (payload sum + checksum byte) mod 256 == 0: go to DONE; done=1, core_hold=0.
  - Otherwise: go to ERR; error=1, core_hold stays 1.
- DONE and ERR: byte_ready=0; outputs hold until the next load_start or reset.
- load_start is ignored in RECV, WRITE and CHECK.
- byte_valid while byte_ready=0 is not consumed; the sender must hold the byte.
- Latency from load_start to first byte_ready=1 is 1 cycle.
- wr_data keeps its last value when wr_en=0.
- Count is 16-bit. Address arithmetic is unsigned and does not wrap within MEM_BYTES, because the length check guarantees it.

Decomposition:
- Shared package imem_pkg holds:
  - the state enum
  - MEM_BYTES and the word-width constant (32)
  - the bytes-per-word constant (4)
- Natural sub-module: imem_word_packer.
  - Contains the lane index, the 4-byte shift/pack register and the word_full flag.
  - Is cleared by the FSM.
  - The FSM, counter, checksum and address remain in imem_loader.

Test Plan:
1. Good load: load_len=8; bytes 13 05 00 00 93 05 40 00; checksum 10 -> writes (addr 0, data 0x00000513) then (addr 4, data 0x00400593), one cycle each; done=1, core_hold=0, error=0.
2. Bad checksum: same payload, checksum 11 -> both writes still occur; error=1, done=0, core_hold=1.
3. Length errors: load_len=6 -> ERR next cycle, no wr_en, byte_ready stays 0. Repeat with load_len=84 and MEM_BYTES=80 -> same result.
4. Backpressure: bytes with random byte_valid gaps -> byte_ready=0 during each WRITE cycle; the byte held across that cycle is taken after it; word data is correct and no byte is dropped or duplicated.
5. Reset mid-load: reset=0 after 3 of 8 bytes -> no write; all outputs at reset values. A following load_start plus the scenario 1 stream -> writes again start at address 0 and the load completes with done=1.
6. Empty image: load_len=0, checksum 00 -> no wr_en, done=1, core_hold=0. A load_start issued while in RECV during another load is ignored: count and address are unaffected.
